timer_counter: RTL and testbench

Memory-mapped countdown timer peripheral, the responder on the CPU data bus for stores and loads decoded to the timer address window. The `mips` core issues 32-bit word reads and writes. The block answers reads combinationally and raises a maskable interrupt request toward the core's exception logic when the count expires. It supports one-shot mode and, optionally, auto-reload mode.

---
 rtl/tc_pkg.sv | 24 ++
 rtl/timer_counter.sv | 122 ++++++++++++
 tb/tb_timer_counter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// tc_pkg: shared constants for the countdown timer peripheral.
// Also imported by the CPU-side bus bridge for address decode.
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer with maskable irq.
// Auto-reload mode is built only when TC_AUTORELOAD_EN is defined.
module timer_counter
  import tc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  state_t           state, state_nxt;
  logic             en, im, irq_flag;
  logic [1:0]       mode;
  logic [WIDTH-1:0] preset, count, count_nxt;
  logic             ctrl_wr, preset_wr;
  logic             flag_set, en_clr;

  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign preset_wr = we && (addr == ADDR_PRESET);
  assign irq       = irq_flag & im;

`ifdef TC_AUTORELOAD_EN
  logic flag_clr;
`else
  assign mode = MODE_ONESHOT;
`endif

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_set  = 1'b0;
    en_clr    = 1'b0;
`ifdef TC_AUTORELOAD_EN
    flag_clr  = 1'b0;
`endif
    unique case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count == '0) begin
          state_nxt = INT;
          flag_set  = 1'b1;
        end else begin
          count_nxt = count - 1'b1;
        end
      end
      INT: begin
`ifdef TC_AUTORELOAD_EN
        if (mode == MODE_RELOAD) begin
          flag_clr  = 1'b1;
          state_nxt = LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = IDLE;
        end
`else
        en_clr    = 1'b1;
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      preset   <= '0;
      en       <= 1'b0;
      im       <= 1'b0;
      irq_flag <= 1'b0;
`ifdef TC_AUTORELOAD_EN
      mode     <= MODE_ONESHOT;
`endif
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (preset_wr) preset <= wdata;
      // software CTRL write wins over the one-shot EN auto-clear
      if (ctrl_wr) begin
        en <= wdata[CTRL_EN];
        im <= wdata[CTRL_IM];
`ifdef TC_AUTORELOAD_EN
        mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
`endif
      end else if (en_clr) begin
        en <= 1'b0;
      end
      if (ctrl_wr)
        irq_flag <= 1'b0;
      else if (flag_set)
        irq_flag <= 1'b1;
`ifdef TC_AUTORELOAD_EN
      else if (flag_clr)
        irq_flag <= 1'b0;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr == ADDR_CTRL:   rdata[3:0] = {im, mode, en};
      addr == ADDR_PRESET: rdata = preset;
      addr == ADDR_COUNT:  rdata = count;
      default:             rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed and randomized checks of timer_counter
// against a closed-form timing model.
module tb_timer_counter;
  import tc_pkg::*;

  logic        clk, reset, we;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  timer_counter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] v, c, cm, mask, ecnt;
  int unsigned p, n, r;
  bit rel, eirq;

  initial begin
    reset = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef TC_AUTORELOAD_EN
    mask = 32'hF;
`else
    mask = 32'h9;
`endif

    // reset mid-count
    do_reset();
    wr(ADDR_PRESET, 32'd10);
    tick(); tick(); tick(); tick();
    wr(ADDR_CTRL, 32'h1);
    tick(); tick();
    rd(ADDR_COUNT, v); chk("pre_reset_count", v, 32'd10);
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v); chk("reset_rdata", v, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_state", {30'd0, dut.state}, {30'd0, IDLE});
    tick(); tick();
    rd(ADDR_COUNT, v); chk("reset_stays", v, 32'd0);

    // one-shot with irq held until a CTRL write
    do_reset();
    wr(ADDR_PRESET, 32'd5);
    wr(ADDR_CTRL, 32'h9);
    for (int t = 1; t <= 8; t++) tick();
    chk("os_irq_rise", {31'd0, irq}, 32'd1);
    tick();
    rd(ADDR_CTRL, v); chk("os_ctrl_en_clr", v, 32'h8);
    tick(); tick(); tick();
    chk("os_irq_hold", {31'd0, irq}, 32'd1);
    rd(2'd3, v); chk("rsvd_read", v, 32'd0);
    wr(ADDR_CTRL, 32'h8);
    chk("os_irq_drop", {31'd0, irq}, 32'd0);

    // masked expiry sets flag; CTRL write clears it
    do_reset();
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h1);
    for (int t = 1; t <= 5; t++) tick();
    chk("mask_irq", {31'd0, irq}, 32'd0);
    chk("mask_flag", {31'd0, dut.irq_flag}, 32'd1);
    wr(ADDR_CTRL, 32'h8);
    chk("mask_flag_clr", {31'd0, dut.irq_flag}, 32'd0);
    tick();
    chk("mask_irq_after", {31'd0, irq}, 32'd0);

    // CTRL write on the INT-entry edge: clear beats set
    do_reset();
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h9);
    for (int t = 1; t <= 4; t++) tick();
    wr(ADDR_CTRL, 32'h9);
    for (int t = 0; t < 4; t++) begin
      chk("overlap_irq", {31'd0, irq}, 32'd0);
      tick();
    end

    // pause, PRESET change, COUNT write ignored, restart
    do_reset();
    wr(ADDR_PRESET, 32'd20);
    wr(ADDR_CTRL, 32'h1);
    for (int t = 1; t <= 9; t++) tick();
    rd(ADDR_COUNT, v); chk("pause_pre", v, 32'd13);
    wr(ADDR_CTRL, 32'h0);
    for (int k = 0; k < 10; k++) begin
      rd(ADDR_COUNT, v); chk("pause_hold", v, 32'd12);
      if (k == 3) wr(ADDR_PRESET, 32'd4);
      else if (k == 5) wr(ADDR_COUNT, 32'h55);
      else tick();
    end
    rd(ADDR_COUNT, v); chk("pause_hold_end", v, 32'd12);
    wr(ADDR_CTRL, 32'h1);
    tick();
    rd(ADDR_COUNT, v); chk("restart_load", v, 32'd12);
    tick();
    rd(ADDR_COUNT, v); chk("restart_new", v, 32'd4);

    // randomized runs against the closed-form timing model
    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(0, 6);
      c = ($urandom & ~32'h6) | 32'((i % 4) << 1) | 32'h1;
      cm = c & mask;
`ifdef TC_AUTORELOAD_EN
      rel = (((c >> 1) & 32'h3) == 32'h1);
`else
      rel = 1'b0;
`endif
      do_reset();
      wr(ADDR_PRESET, 32'(p));
      wr(ADDR_CTRL, c);
      n = 2 * (p + 3) + 3;
      for (int unsigned t = 1; t <= n; t++) begin
        tick();
        r = (t - 1) % (p + 3);
        if (!rel && t > p + 3) r = p + 3;
        ecnt = (r >= 1 && r <= p + 1) ? 32'(p - r + 1) : 32'd0;
        eirq = c[3] && (rel ? (r == p + 2) : (t >= p + 3));
        rd(ADDR_COUNT, v); chk("rnd_count", v, ecnt);
        chk("rnd_irq", {31'd0, irq}, {31'd0, eirq});
        rd(ADDR_CTRL, v);
        chk("rnd_ctrl", v, (!rel && t >= p + 4) ? (cm & ~32'h1) : cm);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
